// File: rtl/dac_update_scheduler_pkg.sv
// Shared sizing, FSM encoding and counter helper for the DAC update scheduler.
// Latest-value-per-channel coalescing between the PID pipeline and the DAC controller.
package dac_update_scheduler_pkg;

  localparam int N_CHAN = 8;
  localparam int W_CHAN = 3;
  localparam int W_DATA = 16;
  localparam int W_CNT  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] v);
    if (v == {W_CNT{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(W_CNT-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/dac_update_scheduler_if.sv
// PID-result capture and DAC-controller issue signals of the scheduler.
// slave = scheduler side, master = PID/DAC side.
interface dac_update_scheduler_if;
  import dac_update_scheduler_pkg::*;

  logic              dv_in;
  logic [W_CHAN-1:0] chan_in;
  logic [W_DATA-1:0] data_in;
  logic              wr_done_in;
  logic              dv_out;
  logic [W_CHAN-1:0] chan_out;
  logic [W_DATA-1:0] data_out;
  logic              busy_out;
  logic [W_CNT-1:0]  coalesce_cnt_out;

  modport slave (
    input  dv_in, chan_in, data_in, wr_done_in,
    output dv_out, chan_out, data_out, busy_out, coalesce_cnt_out
  );

  modport master (
    output dv_in, chan_in, data_in, wr_done_in,
    input  dv_out, chan_out, data_out, busy_out, coalesce_cnt_out
  );

endinterface

// File: rtl/dac_update_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward
// from last+1, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_grant,
  output logic         o_valid
);

  logic [W:0]   w_sum;
  logic [W-1:0] w_idx;

  // Scan farthest-to-nearest so the nearest request after i_last is written last.
  always_comb begin
    o_grant = {W{1'b0}};
    o_valid = 1'b0;
    w_sum   = {(W+1){1'b0}};
    w_idx   = {W{1'b0}};
    for (int i = N; i >= 1; i--) begin
      w_sum = {1'b0, i_last} + (W+1)'(i);
      if (w_sum >= (W+1)'(N)) begin
        w_sum = w_sum - (W+1)'(N);
      end else begin
        w_sum = w_sum;
      end
      w_idx = w_sum[W-1:0];
      if (i_req[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/dac_update_scheduler.sv
// One latest-value slot and pending bit per DAC channel; pending channels drain
// round-robin, one word per wr_done handshake. Newer values overwrite unsent ones.
module dac_update_scheduler
  import dac_update_scheduler_pkg::*;
(
  input logic                    clk_in,
  input logic                    rst_in,
  dac_update_scheduler_if.slave  bus
);

  logic [W_DATA-1:0] r_slot [N_CHAN];
  logic [N_CHAN-1:0] r_pend;
  logic [W_CHAN-1:0] r_last;
  sched_state_e      r_state;
  logic              r_dv;
  logic [W_CHAN-1:0] r_chan;
  logic [W_DATA-1:0] r_data;
  logic              r_busy;
  logic [W_CNT-1:0]  r_cnt;

  logic [W_CHAN-1:0] w_grant;
  logic              w_grant_vld;
  logic              w_cap;
  logic              w_issue;
  logic              w_issue_same;

  rr_arbiter #(
    .N (N_CHAN),
    .W (W_CHAN)
  ) u_arb (
    .i_req   (r_pend),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_valid (w_grant_vld)
  );

  assign w_cap        = bus.dv_in && ({1'b0, bus.chan_in} < (W_CHAN+1)'(N_CHAN));
  assign w_issue      = (r_state == ST_ISSUE) && w_grant_vld;
  assign w_issue_same = w_issue && (w_grant == bus.chan_in);

  // Slot/pending store; capture is written after the issue clear so set beats clear.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pend <= {N_CHAN{1'b0}};
      r_cnt  <= {W_CNT{1'b0}};
      for (int i = 0; i < N_CHAN; i++) begin
        r_slot[i] <= {W_DATA{1'b0}};
      end
    end else begin
      if (w_issue) begin
        r_pend[w_grant] <= 1'b0;
      end
      if (w_cap) begin
        r_slot[bus.chan_in] <= bus.data_in;
        r_pend[bus.chan_in] <= 1'b1;
        if (r_pend[bus.chan_in] && !w_issue_same) begin
          r_cnt <= sat_inc(r_cnt);
        end
      end
    end
  end

  // Issue FSM; IDLE also reacts to a capture this cycle to reach the 2-cycle latency.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
      r_last  <= W_CHAN'(N_CHAN - 1);
      r_dv    <= 1'b0;
      r_chan  <= {W_CHAN{1'b0}};
      r_data  <= {W_DATA{1'b0}};
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_dv <= 1'b0;
          if ((|r_pend) || w_cap) begin
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_grant_vld) begin
            r_dv    <= 1'b1;
            r_chan  <= w_grant;
            r_data  <= r_slot[w_grant];
            r_last  <= w_grant;
            r_busy  <= 1'b1;
            r_state <= ST_WAIT;
          end else begin
            r_dv    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          r_dv <= 1'b0;
          if (bus.wr_done_in) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_dv    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dv_out           = r_dv;
  assign bus.chan_out         = r_chan;
  assign bus.data_out         = r_data;
  assign bus.busy_out         = r_busy;
  assign bus.coalesce_cnt_out = r_cnt;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler: directed scenarios plus random traffic, all
// checked against a per-channel latest-value / round-robin reference model.
module tb_dac_update_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  dac_update_scheduler_if bus();

  dac_update_scheduler dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what is waiting per channel, and what was issued.
  logic [15:0] slot_m [8];
  logic [7:0]  pend_m;
  int          last_m;
  int          cnt_m;
  bit          busy_m;
  int          exp_chan;
  int          exp_data;
  int          iss_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) slot_m[i] = 16'h0000;
    pend_m   = 8'h00;
    last_m   = 7;
    cnt_m    = 0;
    busy_m   = 1'b0;
    exp_chan = 0;
    exp_data = 0;
    iss_q.delete();
  endtask

  // Called once per cycle after the edge that consumed (dv,ch,d,wd).
  task automatic model_update(input bit dv, input int ch, input logic [15:0] d, input bit wd);
    bit was_busy;
    int sel;
    int c;
    was_busy = busy_m;
    if (wd && busy_m) busy_m = 1'b0;
    if (bus.dv_out === 1'b1) begin
      check("issue_not_busy", 32'(was_busy), 32'd0);
      sel = -1;
      for (int k = 1; k <= 8; k++) begin
        c = (last_m + k) % 8;
        if (sel < 0 && pend_m[c]) sel = c;
      end
      check("issue_has_pending", 32'(sel >= 0), 32'd1);
      if (sel >= 0) begin
        check("issue_chan", 32'(bus.chan_out), 32'(sel));
        check("issue_data", 32'(bus.data_out), 32'(slot_m[sel]));
        pend_m[sel] = 1'b0;
        last_m      = sel;
        exp_chan    = sel;
        exp_data    = int'(slot_m[sel]);
        iss_q.push_back(sel);
      end
      busy_m = 1'b1;
    end
    if (dv) begin
      if (pend_m[ch]) cnt_m = (cnt_m < 65535) ? cnt_m + 1 : 65535;
      slot_m[ch] = d;
      pend_m[ch] = 1'b1;
    end
    check("busy", 32'(bus.busy_out), 32'(busy_m));
    check("chan_hold", 32'(bus.chan_out), 32'(exp_chan));
    check("data_hold", 32'(bus.data_out), 32'(exp_data));
    check("coalesce_cnt", 32'(bus.coalesce_cnt_out), 32'(cnt_m));
  endtask

  task automatic tick(input bit dv, input int ch, input logic [15:0] d, input bit wd);
    bus.dv_in      = dv;
    bus.chan_in    = 3'(ch);
    bus.data_in    = d;
    bus.wr_done_in = wd;
    @(posedge clk);
    @(negedge clk);
    model_update(dv, ch, d, wd);
  endtask

  task automatic do_reset();
    bus.dv_in      = 1'b0;
    bus.chan_in    = 3'd0;
    bus.data_in    = 16'h0000;
    bus.wr_done_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dv", 32'(bus.dv_out), 32'd0);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    check("rst_chan", 32'(bus.chan_out), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_cnt", 32'(bus.coalesce_cnt_out), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n5;
    bit seen;
    model_reset();
    #1;
    do_reset();

    // Single write: 2-cycle idle latency, busy until wr_done.
    tick(1'b1, 3, 16'h1234, 1'b0);
    check("single_c1_nodv", 32'(bus.dv_out), 32'd0);
    tick(1'b0, 0, 16'h0000, 1'b0);
    check("single_c2_dv", 32'(bus.dv_out), 32'd1);
    check("single_c2_chan", 32'(bus.chan_out), 32'd3);
    check("single_c2_data", 32'(bus.data_out), 32'h1234);
    repeat (3) tick(1'b0, 0, 16'h0000, 1'b0);
    check("single_busy_hold", 32'(bus.busy_out), 32'd1);
    tick(1'b0, 0, 16'h0000, 1'b1);
    check("single_busy_clr", 32'(bus.busy_out), 32'd0);

    // Coalesce while chan 0 is stalled; wr_done at t gives dv_out at t+3.
    do_reset();
    tick(1'b1, 0, 16'h0ABC, 1'b0);
    tick(1'b0, 0, 16'h0000, 1'b0);
    tick(1'b1, 5, 16'h0001, 1'b0);
    tick(1'b1, 5, 16'h0002, 1'b0);
    tick(1'b0, 0, 16'h0000, 1'b0);
    check("coal_cnt", 32'(bus.coalesce_cnt_out), 32'd1);
    tick(1'b0, 0, 16'h0000, 1'b1);
    check("wd_lat_t1", 32'(bus.dv_out), 32'd0);
    tick(1'b0, 0, 16'h0000, 1'b0);
    check("wd_lat_t2", 32'(bus.dv_out), 32'd0);
    tick(1'b0, 0, 16'h0000, 1'b0);
    check("wd_lat_t3", 32'(bus.dv_out), 32'd1);
    check("coal_data", 32'(bus.data_out), 32'h0002);
    tick(1'b0, 0, 16'h0000, 1'b1);
    repeat (6) tick(1'b0, 0, 16'h0000, 1'b1);
    n5 = 0;
    foreach (iss_q[i]) if (iss_q[i] == 5) n5++;
    check("coal_once", 32'(n5), 32'd1);

    // Round-robin from last = 4 with 1, 4, 6 pending.
    do_reset();
    tick(1'b1, 4, 16'h0044, 1'b0);
    tick(1'b0, 0, 16'h0000, 1'b0);
    tick(1'b1, 4, 16'h0144, 1'b0);
    tick(1'b1, 1, 16'h0011, 1'b0);
    tick(1'b1, 6, 16'h0066, 1'b0);
    iss_q.delete();
    for (int k = 0; k < 40 && iss_q.size() < 3; k++) tick(1'b0, 0, 16'h0000, 1'b1);
    check("rr_count", 32'(iss_q.size()), 32'd3);
    if (iss_q.size() >= 3) begin
      check("rr_first", 32'(iss_q[0]), 32'd6);
      check("rr_second", 32'(iss_q[1]), 32'd1);
      check("rr_third", 32'(iss_q[2]), 32'd4);
    end

    // Set beats clear: capture in the ISSUE cycle of the same channel.
    do_reset();
    tick(1'b1, 2, 16'h00AA, 1'b0);
    tick(1'b1, 2, 16'h00BB, 1'b0);
    check("sbc_first_dv", 32'(bus.dv_out), 32'd1);
    check("sbc_first_data", 32'(bus.data_out), 32'h00AA);
    tick(1'b0, 0, 16'h0000, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick(1'b0, 0, 16'h0000, 1'b0);
      seen = (bus.dv_out === 1'b1);
    end
    check("sbc_second_seen", 32'(seen), 32'd1);
    check("sbc_second_chan", 32'(bus.chan_out), 32'd2);
    check("sbc_second_data", 32'(bus.data_out), 32'h00BB);
    check("sbc_cnt", 32'(bus.coalesce_cnt_out), 32'd0);
    tick(1'b0, 0, 16'h0000, 1'b1);

    // Counter saturation: 0x10001 overwrites of a pending channel.
    do_reset();
    tick(1'b1, 5, 16'h0000, 1'b0);
    tick(1'b0, 0, 16'h0000, 1'b0);
    for (int k = 0; k < 65538; k++) tick(1'b1, 5, k[15:0], 1'b0);
    check("sat_cnt", 32'(bus.coalesce_cnt_out), 32'h0000FFFF);

    // Reset mid-WAIT, then a late wr_done.
    tick(1'b0, 0, 16'h0000, 1'b0);
    check("rstw_in_wait", 32'(bus.busy_out), 32'd1);
    do_reset();
    tick(1'b0, 0, 16'h0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 0, 16'h0000, 1'b0);
      check("rstw_nodv", 32'(bus.dv_out), 32'd0);
    end

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      tick(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           16'($urandom), bit'($urandom_range(0, 2) == 0));
    end

    // Drain: every pending channel must eventually go out.
    for (int k = 0; k < 300 && (pend_m != 8'h00 || busy_m); k++) tick(1'b0, 0, 16'h0000, 1'b1);
    check("drain_pend", 32'(pend_m), 32'd0);
    check("drain_busy", 32'(bus.busy_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_update_scheduler.md
# dac_update_scheduler

Coalescing scheduler between the PID pipeline output and the DAC controller. Keeps one latest-value slot and one pending bit per DAC channel, so a slow serial DAC never backlogs: a newer PID result for a channel overwrites an unsent older one. Pending channels drain round-robin, one word at a time, under the DAC controller's `wr_done` handshake. Replaces the DAC clock-crossing FIFO when PID and DAC share `clk50`.

## Interface
- `N_CHAN`, 8, number of DAC channels served.
- `W_CHAN`, 3, channel index width; `2**W_CHAN >= N_CHAN`.
- `W_DATA`, 16, DAC data word width.
- `W_CNT`, 16, width of the coalesce counter.

Ports:
- `clk_in`  in  1  pid/dac clock (`clk50`).
- `rst_in`  in  1  asynchronous reset, active-low.
- `dv_in`  in  1  PID result valid, single-cycle strobe.
- `chan_in`  in  W_CHAN  PID output channel.
- `data_in`  in  W_DATA  PID output data.
- `wr_done_in`  in  1  DAC controller finished the current word, single-cycle strobe.
- `dv_out`  out  1  word issue strobe to the DAC controller, single cycle.
- `chan_out`  out  W_CHAN  issued channel.
- `data_out`  out  W_DATA  issued data.
- `busy_out`  out  1  a word has been issued and `wr_done_in` has not yet been seen.
- `coalesce_cnt_out`  out  W_CNT  saturating count of overwritten unsent values.

## Operation
- **Capture.** `dv_in` with `chan_in < N_CHAN` writes `data_in` to `slot[chan_in]` and sets `pend[chan_in]`.
  - If `pend[chan_in]` was already set, `coalesce_cnt_out` increments, saturating at all-ones.
  - `chan_in >= N_CHAN` is ignored; no counter change.
- **States.**
  - IDLE: if any `pend` bit is set, go to ISSUE.
  - ISSUE: one cycle. The round-robin arbiter picks the first set `pend` bit, searching upward from `last+1` mod N_CHAN.
    - Registers `chan_out`/`data_out` from that slot and pulses `dv_out`.
    - Clears `pend[sel]`, updates `last = sel`, sets `busy_out`. Go to WAIT.
  - WAIT: hold `chan_out`/`data_out` stable. On `wr_done_in`, clear `busy_out` and go to IDLE.
- **Simultaneous events.**
  - `dv_in` to channel `sel` in the ISSUE cycle: the issued word is the old slot value. The slot takes the new value and `pend` stays set (set beats clear). No coalesce increment.
  - `dv_in` to the in-flight channel during WAIT: updates the slot and sets `pend`. The output registers are unaffected.
- `wr_done_in` outside WAIT is ignored.
- Reset values, held while `rst_in` is low:
  - all `pend` cleared, all `slot` = 0;
  - `last = N_CHAN-1`, so channel 0 wins first;
  - state IDLE; `dv_out`, `busy_out`, `chan_out`, `data_out`, `coalesce_cnt_out` = 0.
- Reset mid-WAIT abandons the in-flight word. Any late `wr_done_in` is ignored.

## Timing
- All outputs are registered.
- Idle latency: `dv_in` at cycle 0 produces the `dv_out` pulse at cycle 2.
  - Cycle 1: slot write visible, IDLE→ISSUE.
  - Cycle 2: ISSUE output registered.
- `wr_done_in` at cycle t puts the state in IDLE at t+1. If anything is pending, the next `dv_out` occurs at t+3. Minimum issue period is `wr_done` latency + 3.
- Fairness: every pending channel is issued within N_CHAN issues of becoming pending.
- Accepts `dv_in` every cycle with no backpressure. There is no FIFO, so there is no full condition; worst-case storage is one value per channel.

## Structure
- `N_DAC`, `W_DAC_CHAN` and `W_DAC_DATA` come from the shared `parameters.vh`. No new constants are needed there.
- Sub-module `rr_arbiter`, parameterised by N:
  - inputs: request vector, last-grant index;
  - outputs: grant index, grant valid.
  - Purely combinational. Reusable later for DDS freq/phase/amp draining.
- State encoding is local: IDLE, ISSUE, WAIT.

## Test plan
- **Single write.** Reset, then `dv_in` chan 3 data 0x1234 → `dv_out` 2 cycles later with chan 3, 0x1234. `busy_out` stays high until `wr_done_in`, then returns to 0.
- **Coalesce.** Stall `wr_done_in` on chan 0. Write chan 5 = 0x0001, then chan 5 = 0x0002 → after release, exactly one chan-5 issue with 0x0002; `coalesce_cnt_out` = 1.
- **Round-robin.** Set pending on chans 1, 4 and 6, with `last` = 4 → issue order 6, 1, 4. After reset, with chans 0 and 7 pending, chan 0 is issued first.
- **Set beats clear.** In the ISSUE cycle for chan 2 (old 0x00AA), inject chan 2 = 0x00BB → issued data 0x00AA. A second issue of chan 2 with 0x00BB follows; counter unchanged.
- **Edge conditions.**
  - `chan_in` = 8 with N_CHAN = 8 → ignored, no issue.
  - 0x1_0000 overwrites with W_CNT = 16 → counter saturates at 0xFFFF.
- **Reset mid-WAIT.** Pull `rst_in` low mid-WAIT, release, then pulse `wr_done_in` → all outputs 0, no `dv_out`.
